// File: rtl/loader_pkg.sv
// loader_pkg: instruction memory geometry and loader state encoding shared with the control unit
package loader_pkg;
  localparam int IM_DEPTH = 128;
  localparam int IM_ADDR_W = $clog2(IM_DEPTH);
  localparam int BYTES_PER_WORD = 2;
  localparam int IM_DATA_W = 8 * BYTES_PER_WORD;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_HI,
    S_RX_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } loader_state_t;
endpackage

// File: rtl/loader_checksum.sv
// loader_checksum: running XOR of accepted stream bytes
module loader_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] byte_in,
  output logic [7:0] sum
);
  always_ff @(posedge clk)
    sum <= (rst || clear) ? '0 : en ? sum ^ byte_in : sum;
endmodule

// File: rtl/program_loader.sv
// program_loader: packs a byte stream into 16-bit words, writes instruction memory and verifies an XOR checksum
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int DEPTH  = IM_DEPTH,
  parameter int DATA_W = IM_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W:0]   Word_Count,
  input  logic [7:0]        Byte_In,
  input  logic              Byte_Valid,
  output logic              Byte_Ready,
  output logic              IM_Wr,
  output logic [ADDR_W-1:0] IM_Addr,
  output logic [DATA_W-1:0] IM_Data,
  output logic              CPU_Hold,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];
  loader_state_t state, state_n;
  logic [ADDR_W-1:0] addr, last;
  logic [7:0] hi, sum;
  logic xfer, count_ok, start_go, can_start;
  assign Byte_Ready = state inside {S_RX_HI, S_RX_LO, S_CHECK};
  assign IM_Wr = state == S_WRITE;
  assign Busy = Byte_Ready | IM_Wr;
  assign Done = state == S_DONE;
  assign Error = state == S_ERROR;
  assign CPU_Hold = Busy | Error;
  assign xfer = Byte_Valid & Byte_Ready;
  assign count_ok = Word_Count != '0 && Word_Count <= DEPTH_W;
  assign can_start = state == S_IDLE || state == S_ERROR;
  assign start_go = can_start & Start & count_ok;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_ERROR: state_n = Start ? (count_ok ? S_RX_HI : S_ERROR) : state;
      S_RX_HI:         state_n = xfer ? S_RX_LO : state;
      S_RX_LO:         state_n = xfer ? S_WRITE : state;
      S_WRITE:         state_n = addr == last ? S_CHECK : S_RX_HI;
      S_CHECK:         state_n = xfer ? (Byte_In == sum ? S_DONE : S_ERROR) : state;
      default:         state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      addr    <= '0;
      last    <= '0;
      hi      <= '0;
      IM_Addr <= '0;
      IM_Data <= '0;
    end else begin
      state <= state_n;
      if (start_go) begin
        addr <= '0;
        last <= Word_Count[ADDR_W-1:0] - ADDR_W'(1);
      end
      if (xfer && state == S_RX_HI) hi <= Byte_In;
      if (xfer && state == S_RX_LO) begin
        IM_Addr <= addr;
        IM_Data <= {hi, Byte_In};
      end
      if (state == S_WRITE && addr != last) addr <= addr + ADDR_W'(1);
    end
  end
  loader_checksum u_checksum (
    .clk     (Clk),
    .rst     (Reset),
    .clear   (start_go),
    .en      (xfer && (state == S_RX_HI || state == S_RX_LO)),
    .byte_in (Byte_In),
    .sum     (sum)
  );
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed, table-driven and randomized checks of program_loader against a byte-stream model
module tb_program_loader;
  logic Clk = 0, Reset = 1, Start = 0, Byte_Valid = 0;
  logic [7:0] Word_Count = 0, Byte_In = 0;
  logic Byte_Ready, IM_Wr, CPU_Hold, Busy, Done, Error;
  logic [6:0] IM_Addr;
  logic [15:0] IM_Data;
  int n_vec = 0, n_err = 0, done_cnt = 0;
  logic [22:0] wr_q[$];
  typedef struct {
    logic [7:0] wc;
    logic ready, busy, hold, err;
  } start_vec_t;
  start_vec_t sv[4];
  program_loader dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Word_Count(Word_Count),
    .Byte_In(Byte_In), .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready),
    .IM_Wr(IM_Wr), .IM_Addr(IM_Addr), .IM_Data(IM_Data), .CPU_Hold(CPU_Hold),
    .Busy(Busy), .Done(Done), .Error(Error)
  );
  always #5 Clk = ~Clk;
  always @(negedge Clk) begin
    if (IM_Wr) wr_q.push_back({IM_Addr, IM_Data});
    if (Done) done_cnt++;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  function automatic logic [31:0] outs();
    return {3'b0, Byte_Ready, IM_Wr, IM_Addr, IM_Data, CPU_Hold, Busy, Done, Error};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    Reset = 1; Start = 0; Byte_Valid = 0;
    repeat (2) @(negedge Clk);
    Reset = 0;
  endtask
  task automatic pulse_start(input logic [7:0] wc);
    Start = 1; Word_Count = wc;
    @(negedge Clk);
    Start = 0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    Byte_Valid = 0;
    repeat (gap) @(negedge Clk);
    Byte_Valid = 1; Byte_In = b; t = 0;
    while (!Byte_Ready && t < 50) begin
      @(negedge Clk);
      t++;
    end
    if (t == 50) check("ready timeout", 0, 1);
    @(negedge Clk);
    Byte_Valid = 0;
  endtask
  task automatic do_load(input int n, input logic [7:0] data[$], input logic [7:0] cks,
                         input int gmax, input bit poke, input string tag);
    logic [7:0] x;
    bit ok;
    x = 0;
    wr_q.delete();
    done_cnt = 0;
    pulse_start(8'(n));
    for (int i = 0; i < 2 * n; i++) begin
      send_byte(data[i], gmax > 0 ? int'($urandom_range(gmax, 0)) : 0);
      if (poke && i == 0) pulse_start(8'd1);
      x ^= data[i];
    end
    send_byte(cks, 0);
    ok = cks == x;
    check({tag, " done"}, Done, ok);
    check({tag, " error"}, Error, !ok);
    check({tag, " hold"}, CPU_Hold, !ok);
    check({tag, " writes"}, wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++)
      check({tag, " word"}, wr_q[i], {7'(i), data[2*i], data[2*i+1]});
    @(negedge Clk);
    check({tag, " done pulses"}, done_cnt, ok);
    check({tag, " busy after"}, Busy, 0);
  endtask
  initial begin
    logic [7:0] d[$];
    int n;
    bit bad;
    sv[0] = '{8'd0,   1'b0, 1'b0, 1'b1, 1'b1};
    sv[1] = '{8'd129, 1'b0, 1'b0, 1'b1, 1'b1};
    sv[2] = '{8'd255, 1'b0, 1'b0, 1'b1, 1'b1};
    sv[3] = '{8'd128, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) check("idle outputs", outs(), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("idle outputs", outs(), 0);
    end
    check("idle writes", wr_q.size(), 0);
    d = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    do_load(2, d, 8'h40, 0, 0, "good cks");
    do_load(2, d, 8'h41, 0, 0, "bad cks");
    pulse_start(8'd1);
    check("restart clears error", Error, 0);
    check("restart busy", Busy, 1);
    do_reset();
    wr_q.delete();
    for (int i = 0; i < 4; i++) begin
      pulse_start(sv[i].wc);
      check("start ready", Byte_Ready, sv[i].ready);
      check("start busy", Busy, sv[i].busy);
      check("start hold", CPU_Hold, sv[i].hold);
      check("start error", Error, sv[i].err);
      repeat (2) @(negedge Clk);
      check("start ready held", Byte_Ready, sv[i].ready);
    end
    check("bad count writes", wr_q.size(), 0);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(8, 1);
      bad = $urandom_range(2, 0) == 0;
      d.delete();
      for (int i = 0; i < 2 * n; i++) d.push_back(8'($urandom));
      n = n;
      begin
        logic [7:0] x;
        x = 0;
        foreach (d[i]) x ^= d[i];
        do_load(n, d, bad ? x ^ 8'(1 << $urandom_range(7, 0)) : x, k < 4 ? 0 : 3, k >= 4, "random");
        do_load(n, d, bad ? ~x : x, 3, 1, "random gaps");
      end
    end
    do_reset();
    wr_q.delete();
    pulse_start(8'd4);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    Reset = 1;
    @(negedge Clk);
    check("mid-load reset outputs", outs(), 0);
    check("mid-load reset writes", wr_q.size(), 1);
    Reset = 0;
    @(negedge Clk);
    d.delete();
    begin
      logic [7:0] x;
      x = 0;
      for (int i = 0; i < 256; i++) begin
        d.push_back(8'($urandom));
        x ^= d[i];
      end
      do_load(128, d, x, 1, 0, "full load");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
